// File: rtl/snake_engine_if.sv
// rtl/snake_engine_if.sv - control/observation bundle between game logic and snake_engine
//
// Purpose: groups the snake engine's command inputs and body/status outputs.
// Ports (signals):
//   start, step, grow, key[1:0]          commands from game-tick/input logic
//   body_xy[MAX_LEN*2*CW-1:0]            packed segments, i=0 is head, each {y,x}
//   len[15:0], dir[1:0]                  current length and direction
//   done, dead, hit_wall, hit_self       step completion pulse and status flags
// Modports: master drives commands, slave (the engine) drives results.
interface snake_engine_if #(
  parameter int CW      = 8,
  parameter int MAX_LEN = 64
);
  logic                    start;
  logic                    step;
  logic                    grow;
  logic [1:0]              key;
  logic [MAX_LEN*2*CW-1:0] body_xy;
  logic [15:0]             len;
  logic [1:0]              dir;
  logic                    done;
  logic                    dead;
  logic                    hit_wall;
  logic                    hit_self;

  modport master (
    output start, step, grow, key,
    input  body_xy, len, dir, done, dead, hit_wall, hit_self
  );

  modport slave (
    input  start, step, grow, key,
    output body_xy, len, dir, done, dead, hit_wall, hit_self
  );
endinterface

// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake body update engine with wall/wrap and self-collision checks
//
// Purpose: holds head-first segment coordinates and applies one move per honoured step,
// with reversal rejection, optional growth, wall or wrap edges and self-collision detection.
// A one-cycle done pulse follows every honoured step and kicks the renderer's refresh.
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   snake_engine_if.slave: start/step/grow/key in; body_xy/len/dir/done/dead/
//         hit_wall/hit_self out
module snake_engine #(
  parameter int SIZE_X   = 16,
  parameter int SIZE_Y   = 16,
  parameter int CW       = 8,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 4,
  parameter int START_X  = 4,
  parameter int START_Y  = 4,
  parameter int WRAP     = 0
) (
  input logic           clk,
  input logic           rst,
  snake_engine_if.slave bus
);

  localparam int SW = 2 * CW;
  localparam logic [CW-1:0] X_LAST = CW'(SIZE_X - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(SIZE_Y - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] body_q [MAX_LEN];
  logic [SW-1:0] body_d [MAX_LEN];
  logic [15:0]   len_q, len_d;
  logic [1:0]    dir_q, dir_d;
  logic          done_q, done_d;
  logic          hit_wall_q, hit_wall_d;
  logic          hit_self_q, hit_self_d;

  logic [CW-1:0] head_x, head_y;
  logic [CW-1:0] nx, ny;
  logic [1:0]    nd;
  logic          wall;
  logic          self_hit;
  logic          grow_eff;
  logic [15:0]   len_new;
  logic [15:0]   chk_len;

  // Next-head computation. Edge detection compares the pre-move coordinate against
  // the field limit so CW-bit overflow never masks a wall hit.
  always_comb begin
    head_x   = body_q[0][CW-1:0];
    head_y   = body_q[0][SW-1:CW];
    nd       = ((bus.key ^ dir_q) == 2'b11) ? dir_q : bus.key;
    nx       = head_x;
    ny       = head_y;
    wall     = 1'b0;
    case (nd)
      2'b00: begin
        if (head_y == Y_LAST) begin
          wall = (WRAP == 0);
          ny   = '0;
        end else begin
          ny = head_y + CW'(1);
        end
      end
      2'b11: begin
        if (head_y == '0) begin
          wall = (WRAP == 0);
          ny   = Y_LAST;
        end else begin
          ny = head_y - CW'(1);
        end
      end
      2'b10: begin
        if (head_x == X_LAST) begin
          wall = (WRAP == 0);
          nx   = '0;
        end else begin
          nx = head_x + CW'(1);
        end
      end
      default: begin
        if (head_x == '0) begin
          wall = (WRAP == 0);
          nx   = X_LAST;
        end else begin
          nx = head_x - CW'(1);
        end
      end
    endcase

    grow_eff = bus.grow && (len_q < 16'(MAX_LEN));
    len_new  = len_q + {15'd0, grow_eff};
    // The tail vacates its cell on a plain move, so it only counts when growing.
    chk_len  = grow_eff ? len_q : (len_q - 16'd1);

    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((16'(i) < chk_len) && (body_q[i] == {ny, nx})) begin
        self_hit = 1'b1;
      end
    end
    // A wall death reports only the wall; the off-field head is not a real cell.
    if (wall) begin
      self_hit = 1'b0;
    end
  end

  // Next-state and update logic.
  always_comb begin
    state_d    = state_q;
    body_d     = body_q;
    len_d      = len_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    hit_wall_d = hit_wall_q;
    hit_self_d = hit_self_q;

    if (bus.start) begin
      state_d    = S_RUN;
      len_d      = 16'(INIT_LEN);
      dir_d      = 2'b10;
      hit_wall_d = 1'b0;
      hit_self_d = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_d[i] = (i < INIT_LEN) ? {CW'(START_Y), CW'(START_X - i)} : '0;
      end
    end else if ((state_q == S_RUN) && bus.step) begin
      done_d = 1'b1;
      if (wall || self_hit) begin
        state_d    = S_DEAD;
        hit_wall_d = wall;
        hit_self_d = self_hit;
      end else begin
        body_d[0] = {ny, nx};
        for (int i = 1; i < MAX_LEN; i++) begin
          body_d[i] = (16'(i) < len_new) ? body_q[i-1] : '0;
        end
        len_d = len_new;
        dir_d = nd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_q[i] <= '0;
      end
      len_q      <= '0;
      dir_q      <= 2'b10;
      done_q     <= 1'b0;
      hit_wall_q <= 1'b0;
      hit_self_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      body_q     <= body_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      hit_wall_q <= hit_wall_d;
      hit_self_q <= hit_self_d;
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign bus.body_xy[g*SW +: SW] = body_q[g];
  end

  assign bus.len      = len_q;
  assign bus.dir      = dir_q;
  assign bus.done     = done_q;
  assign bus.dead     = (state_q == S_DEAD);
  assign bus.hit_wall = hit_wall_q;
  assign bus.hit_self = hit_self_q;

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - scoreboard bench for snake_engine (WRAP=0/64 and WRAP=1/5 instances)
module tb_snake_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_engine_if #(.CW(8), .MAX_LEN(64)) if0 ();
  snake_engine_if #(.CW(8), .MAX_LEN(5))  if1 ();

  snake_engine #(.MAX_LEN(64), .WRAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  snake_engine #(.MAX_LEN(5),  .WRAP(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct packed {
    logic [1023:0] body;
    logic [15:0]   len;
    logic [1:0]    dir;
    logic          dead;
    logic          hw;
    logic          hs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state 0 idle, 1 run, 2 dead; directions 0 up, 1 left, 3 down, 2 right.
  int m_st  [2];
  int m_len [2];
  int m_dir [2];
  int m_hw  [2];
  int m_hs  [2];
  int m_x   [2][64];
  int m_y   [2][64];
  int p_max [2] = '{64, 5};
  int p_wrap[2] = '{0, 1};

  function automatic int opposite(int d);
    case (d)
      0: return 3;
      3: return 0;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic exp_t snap(int k);
    exp_t e;
    e = '0;
    for (int i = 0; i < m_len[k]; i++) begin
      e.body[i*16 +: 16] = {8'(m_y[k][i]), 8'(m_x[k][i])};
    end
    e.len  = 16'(m_len[k]);
    e.dir  = 2'(m_dir[k]);
    e.dead = (m_st[k] == 2);
    e.hw   = (m_hw[k] != 0);
    e.hs   = (m_hs[k] != 0);
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_len[k] = 0; m_dir[k] = 2; m_hw[k] = 0; m_hs[k] = 0;
      for (int i = 0; i < 64; i++) begin
        m_x[k][i] = 0; m_y[k][i] = 0;
      end
    end
  endtask

  task automatic model_start(int k);
    m_st[k] = 1; m_len[k] = 4; m_dir[k] = 2; m_hw[k] = 0; m_hs[k] = 0;
    for (int i = 0; i < 64; i++) begin
      m_x[k][i] = (i < 4) ? 4 - i : 0;
      m_y[k][i] = (i < 4) ? 4 : 0;
    end
  endtask

  task automatic model_step(int k, int key, int grow);
    int nd, nx, ny, wall, self_hit, geff, n_chk;
    if (m_st[k] != 1) return;
    nd = (key == opposite(m_dir[k])) ? m_dir[k] : key;
    nx = m_x[k][0];
    ny = m_y[k][0];
    case (nd)
      0: ny = ny + 1;
      3: ny = ny - 1;
      2: nx = nx + 1;
      default: nx = nx - 1;
    endcase
    wall = 0;
    if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
      if (p_wrap[k] != 0) begin
        nx = (nx + 16) % 16;
        ny = (ny + 16) % 16;
      end else begin
        wall = 1;
      end
    end
    geff = (grow != 0 && m_len[k] < p_max[k]) ? 1 : 0;
    self_hit = 0;
    if (wall == 0) begin
      n_chk = (geff != 0) ? m_len[k] : m_len[k] - 1;
      for (int i = 0; i < n_chk; i++) begin
        if (m_x[k][i] == nx && m_y[k][i] == ny) self_hit = 1;
      end
    end
    if (wall != 0 || self_hit != 0) begin
      m_st[k] = 2; m_hw[k] = wall; m_hs[k] = self_hit;
    end else begin
      m_len[k] = m_len[k] + geff;
      for (int i = m_len[k] - 1; i >= 1; i--) begin
        m_x[k][i] = m_x[k][i-1];
        m_y[k][i] = m_y[k][i-1];
      end
      m_x[k][0] = nx;
      m_y[k][0] = ny;
      m_dir[k]  = nd;
    end
    if (k == 0) q0.push_back(snap(0));
    else        q1.push_back(snap(1));
  endtask

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_exp(string name, exp_t act, exp_t exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got len=%0d dir=%0d dead=%0d hw=%0d hs=%0d body=%h expected len=%0d dir=%0d dead=%0d hw=%0d hs=%0d body=%h",
               name, act.len, act.dir, act.dead, act.hw, act.hs, act.body[127:0],
               exp.len, exp.dir, exp.dead, exp.hw, exp.hs, exp.body[127:0]);
    end
  endtask

  function automatic exp_t observe(int k);
    exp_t a;
    if (k == 0) begin
      a.body = 1024'(if0.body_xy); a.len = if0.len; a.dir = if0.dir;
      a.dead = if0.dead; a.hw = if0.hit_wall; a.hs = if0.hit_self;
    end else begin
      a.body = 1024'(if1.body_xy); a.len = if1.len; a.dir = if1.dir;
      a.dead = if1.dead; a.hw = if1.hit_wall; a.hs = if1.hit_self;
    end
    return a;
  endfunction

  function automatic int seg_x(int k, int i);
    exp_t a;
    logic [15:0] s;
    a = observe(k);
    s = a.body[i*16 +: 16];
    return int'(s[7:0]);
  endfunction

  function automatic int seg_y(int k, int i);
    exp_t a;
    logic [15:0] s;
    a = observe(k);
    s = a.body[i*16 +: 16];
    return int'(s[15:8]);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (if0.done) begin
        if (q0.size() == 0) chk("dut0_unexpected_done", 1, 0);
        else begin e = q0.pop_front(); cmp_exp("dut0_step", observe(0), e); end
      end
      if (if1.done) begin
        if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
        else begin e = q1.pop_front(); cmp_exp("dut1_step", observe(1), e); end
      end
    end
  endtask

  task automatic cyc(logic s, logic st, logic g, logic [1:0] key);
    if0.start = s; if0.step = st; if0.grow = g; if0.key = key;
    if1.start = s; if1.step = st; if1.grow = g; if1.key = key;
    if (s) begin
      model_start(0); model_start(1);
    end else if (st) begin
      model_step(0, int'(key), int'(g)); model_step(1, int'(key), int'(g));
    end
    @(posedge clk); #1;
    if0.start = 0; if0.step = 0; if0.grow = 0;
    if1.start = 0; if1.step = 0; if1.grow = 0;
  endtask

  initial begin
    int r;
    rst = 1'b1;
    if0.start = 0; if0.step = 0; if0.grow = 0; if0.key = 2'b10;
    if1.start = 0; if1.step = 0; if1.grow = 0; if1.key = 2'b10;
    model_reset();
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_len", int'(if0.len), 0);
    chk("rst_dir", int'(if0.dir), 2);
    chk("rst_flags", int'({if0.done, if0.dead, if0.hit_wall, if0.hit_self}), 0);
    chk("rst_body_zero", int'(if0.body_xy == '0), 1);
    chk("rst_dut1_body_zero", int'(if1.body_xy == '0), 1);

    // Start defaults
    cyc(1, 0, 0, 2'b10);
    chk("start_len", int'(if0.len), 4);
    chk("start_head_x", seg_x(0, 0), 4);
    chk("start_head_y", seg_y(0, 0), 4);
    chk("start_tail_x", seg_x(0, 3), 1);
    chk("start_dir", int'(if0.dir), 2);
    chk("start_no_done", int'(if0.done), 0);

    // Three back-to-back moves right
    repeat (3) cyc(0, 1, 0, 2'b10);
    chk("right3_head_x", seg_x(0, 0), 7);
    chk("right3_tail_x", seg_x(0, 3), 4);
    chk("right3_len", int'(if0.len), 4);

    // Reversal rejected, then up
    cyc(1, 0, 0, 2'b10);
    cyc(0, 1, 0, 2'b01);
    chk("rev_dir", int'(if0.dir), 2);
    chk("rev_head_x", seg_x(0, 0), 5);
    cyc(0, 1, 0, 2'b00);
    chk("up_head_y", seg_y(0, 0), 5);

    // Growth, with the length cap on the MAX_LEN=5 instance
    cyc(1, 0, 0, 2'b10);
    repeat (2) cyc(0, 1, 1, 2'b10);
    chk("grow_len", int'(if0.len), 6);
    chk("grow_tail_x", seg_x(0, 5), 1);
    chk("grow_capped_len", int'(if1.len), 5);

    // Run into the right edge: fatal without wrap, wraps with wrap
    cyc(1, 0, 0, 2'b10);
    repeat (12) cyc(0, 1, 0, 2'b10);
    chk("wall_dead", int'(if0.dead), 1);
    chk("wall_flag", int'(if0.hit_wall), 1);
    chk("wall_frozen_x", seg_x(0, 0), 15);
    chk("wrap_head_x", seg_x(1, 0), 0);
    chk("wrap_alive", int'(if1.dead), 0);
    cyc(0, 1, 0, 2'b10);

    // Self collision after growing to 5
    cyc(1, 0, 0, 2'b10);
    chk("restart_flags", int'({if0.dead, if0.hit_wall}), 0);
    cyc(0, 1, 1, 2'b10);
    cyc(0, 1, 0, 2'b00);
    cyc(0, 1, 0, 2'b01);
    cyc(0, 1, 0, 2'b11);
    chk("self_flag", int'(if0.hit_self), 1);
    chk("self_dead", int'(if0.dead), 1);
    chk("self_frozen_x", seg_x(0, 0), 4);
    chk("self_dut1_flag", int'(if1.hit_self), 1);
    cyc(1, 0, 0, 2'b10);
    chk("self_restart_len", int'(if0.len), 4);
    chk("self_restart_flags", int'({if0.dead, if0.hit_self}), 0);

    // Randomized play
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3 || ((m_st[0] != 1 || m_st[1] != 1) && r < 15))
        cyc(1, $urandom_range(0, 1) == 1, 0, 2'($urandom_range(0, 3)));
      else if (r < 80)
        cyc(0, 1, $urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)));
      else
        cyc(0, 0, 0, 2'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
